lcd_bus_responder: RTL and testbench

- Receiving end of the HD44780-style character-LCD write bus driven by the system LCD path.
- Decodes EN-strobed command/data writes and keeps a 32-character (2x16) shadow of display RAM, a cursor, display-on state and HD44780-like busy timing.
- Exposes a read port for the bench or on-chip checker, and flags writes issued while busy.
- Sits on LCD_clk beside the LCD driver as a synthesizable bus model/monitor.

---
 rtl/lcd_bus_responder_if.sv | 30 +++
 rtl/lcd_bus_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_responder_if.sv
// lcd_bus_responder_if: HD44780-style write bus plus the shadow read
// port and status outputs of the responder.
interface lcd_bus_responder_if;
   logic [7:0] LCD_DATA;
   logic       LCD_RS;
   logic       LCD_RW;
   logic       LCD_EN;
   logic       LCD_ON;
   logic [4:0] rd_addr;
   logic [7:0] rd_char;
   logic [4:0] cursor;
   logic       busy;
   logic       display_on;
   logic       cmd_valid;
   logic       data_valid;
   logic [7:0] cmd_byte;
   logic       protocol_err;

   modport slave (
      input  LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, rd_addr,
      output rd_char, cursor, busy, display_on,
      output cmd_valid, data_valid, cmd_byte, protocol_err
   );

   modport master (
      output LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, rd_addr,
      input  rd_char, cursor, busy, display_on,
      input  cmd_valid, data_valid, cmd_byte, protocol_err
   );
endinterface

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: character-LCD bus model keeping a 2x16 DDRAM
// shadow, cursor, display-on flag and HD44780-like busy timing.
module lcd_bus_responder #(
   parameter int BUSY_CYCLES  = 2000,
   parameter int CLEAR_CYCLES = 82000
) (
   input logic                LCD_clk,
   input logic                SYS_rst,
   lcd_bus_responder_if.slave bus
);

   localparam int MAX_CYC =
      (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
   localparam int CW = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES - 1);
   localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_BUSY     = 2'd1,
      S_CLEARING = 2'd2
   } state_t;

   logic [7:0] r_q1_data;
   logic       r_q1_rs;
   logic       r_q1_rw;
   logic       r_q1_en;
   logic       r_q1_on;
   logic       r_q2_en;

   logic       r_p_vld;
   logic       r_p_rs;
   logic [7:0] r_p_data;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [4:0] r_clr_addr;
   logic       w_clr_we;

   logic [7:0] r_shadow [32];
   logic [7:0] r_rd_char;
   logic [4:0] r_cursor;
   logic       r_inc;
   logic       r_display_on;
   logic       r_cmd_valid;
   logic       r_data_valid;
   logic [7:0] r_cmd_byte;
   logic       r_err;

   logic       w_strobe;
   logic       w_busy;
   logic       w_accept;
   logic       w_drop;
   logic       w_acc_cmd;
   logic       w_acc_dat;
   logic       w_is_clear;
   logic       w_is_home;
   logic       w_is_entry;
   logic       w_is_disp;
   logic       w_is_addr;
   logic [6:0] w_a;
   logic       w_addr_ok;
   logic [4:0] w_addr_cur;
   logic       w_long;
   logic       w_start_clear;

   assign w_strobe = r_q2_en & ~r_q1_en;
   assign w_busy   = (r_state != S_IDLE);
   assign w_accept = r_p_vld & ~w_busy;
   assign w_drop   = r_p_vld & w_busy;
   assign w_acc_cmd = w_accept & ~r_p_rs;
   assign w_acc_dat = w_accept & r_p_rs;

   // Address set: 0x00-0x0F is row 0, 0x40-0x4F is row 1.
   assign w_a        = r_p_data[6:0];
   assign w_addr_ok  = (w_a[5:4] == 2'b00) & ~w_a[6] |
                       (w_a[5:4] == 2'b00) & w_a[6];
   assign w_addr_cur = {w_a[6], w_a[3:0]};

   assign w_long        = w_is_clear | w_is_home;
   assign w_start_clear = w_acc_cmd & w_is_clear;

   // Bus sampling, falling-EN detect and one decode pipeline stage.
   always_ff @(posedge LCD_clk) begin
      if (!SYS_rst) begin
         r_q1_data <= 8'h00;
         r_q1_rs   <= 1'b0;
         r_q1_rw   <= 1'b0;
         r_q1_en   <= 1'b0;
         r_q1_on   <= 1'b0;
         r_q2_en   <= 1'b0;
         r_p_vld   <= 1'b0;
         r_p_rs    <= 1'b0;
         r_p_data  <= 8'h00;
      end else begin
         r_q1_data <= bus.LCD_DATA;
         r_q1_rs   <= bus.LCD_RS;
         r_q1_rw   <= bus.LCD_RW;
         r_q1_en   <= bus.LCD_EN;
         r_q1_on   <= bus.LCD_ON;
         r_q2_en   <= r_q1_en;
         r_p_vld   <= w_strobe & ~r_q1_rw & r_q1_on;
         r_p_rs    <= r_q1_rs;
         r_p_data  <= r_q1_data;
      end
   end

   // Instruction class of the byte waiting in the decode stage.
   always_comb begin
      w_is_clear = 1'b0;
      w_is_home  = 1'b0;
      w_is_entry = 1'b0;
      w_is_disp  = 1'b0;
      w_is_addr  = 1'b0;
      unique case (1'b1)
         r_p_data[7]:                    w_is_addr  = 1'b1;
         (r_p_data[7:3] == 5'b00001):    w_is_disp  = 1'b1;
         (r_p_data[7:2] == 6'b000001):   w_is_entry = 1'b1;
         (r_p_data[7:1] == 7'b0000001):  w_is_home  = 1'b1;
         (r_p_data == 8'h01):            w_is_clear = 1'b1;
         default: ;
      endcase
   end

   // Busy state register, countdown and clear-sweep address.
   always_ff @(posedge LCD_clk) begin
      if (!SYS_rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_clr_addr <= 5'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_start_clear)
            r_clr_addr <= 5'd0;
         else if (r_state == S_CLEARING)
            r_clr_addr <= r_clr_addr + 5'd1;
      end
   end

   // Next busy state; the clear sweep runs inside the busy window.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr_we    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_start_clear ? S_CLEARING : S_BUSY;
               w_cnt_nxt   = (~r_p_rs & w_long) ? CLEAR_LOAD : BUSY_LOAD;
            end
         end
         S_BUSY: begin
            if (r_cnt == '0)
               w_state_nxt = S_IDLE;
            else
               w_cnt_nxt = r_cnt - 1'b1;
         end
         S_CLEARING: begin
            w_clr_we = 1'b1;
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
               if (r_clr_addr == 5'd31)
                  w_state_nxt = S_BUSY;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Cursor, modes, pulses and the sticky error flag.
   always_ff @(posedge LCD_clk) begin
      if (!SYS_rst) begin
         r_cursor     <= 5'd0;
         r_inc        <= 1'b1;
         r_display_on <= 1'b0;
         r_cmd_valid  <= 1'b0;
         r_data_valid <= 1'b0;
         r_cmd_byte   <= 8'h00;
         r_err        <= 1'b0;
      end else begin
         r_cmd_valid  <= 1'b0;
         r_data_valid <= 1'b0;
         if (w_drop)
            r_err <= 1'b1;
         if (w_acc_dat) begin
            r_data_valid <= 1'b1;
            r_cmd_byte   <= r_p_data;
            r_cursor     <= r_inc ? r_cursor + 5'd1 : r_cursor - 5'd1;
         end
         if (w_acc_cmd) begin
            r_cmd_valid <= 1'b1;
            r_cmd_byte  <= r_p_data;
            if (w_is_clear) begin
               r_cursor <= 5'd0;
               r_inc    <= 1'b1;
            end
            if (w_is_home)
               r_cursor <= 5'd0;
            if (w_is_entry)
               r_inc <= r_p_data[1];
            if (w_is_disp)
               r_display_on <= r_p_data[2];
            if (w_is_addr) begin
               if (w_addr_ok)
                  r_cursor <= w_addr_cur;
               else
                  r_err <= 1'b1;
            end
         end
      end
   end

   // Shadow DDRAM: clear sweep or a single data write per cycle.
   always_ff @(posedge LCD_clk) begin
      if (!SYS_rst) begin
         for (int i = 0; i < 32; i++)
            r_shadow[i] <= 8'h20;
      end else if (w_clr_we) begin
         r_shadow[r_clr_addr] <= 8'h20;
      end else if (w_acc_dat) begin
         r_shadow[r_cursor] <= r_p_data;
      end
   end

   // Registered read port; same-cycle writes show next cycle.
   always_ff @(posedge LCD_clk) begin
      if (!SYS_rst)
         r_rd_char <= 8'h00;
      else
         r_rd_char <= r_shadow[bus.rd_addr];
   end

   assign bus.rd_char      = r_rd_char;
   assign bus.cursor       = r_cursor;
   assign bus.busy         = w_busy;
   assign bus.display_on   = r_display_on;
   assign bus.cmd_valid    = r_cmd_valid;
   assign bus.data_valid   = r_data_valid;
   assign bus.cmd_byte     = r_cmd_byte;
   assign bus.protocol_err = r_err;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: randomized bench for lcd_bus_responder with a
// behavioural DDRAM/cursor/busy-window reference model.
module tb_lcd_bus_responder;

   localparam int BC = 4;
   localparam int CC = 40;
   localparam int HN = 16384;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   logic bh  [HN];
   logic cvh [HN];
   logic dvh [HN];

   logic [7:0] m_sh [32];
   logic [4:0] m_cur;
   bit         m_inc;
   bit         m_don;
   bit         m_err;
   logic [7:0] m_cb;
   int         m_bs;
   int         m_bl;

   lcd_bus_responder_if bus ();

   lcd_bus_responder #(
      .BUSY_CYCLES  (BC),
      .CLEAR_CYCLES (CC)
   ) dut (
      .LCD_clk (clk),
      .SYS_rst (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < HN) begin
         bh[cyc]  = bus.busy;
         cvh[cyc] = bus.cmd_valid;
         dvh[cyc] = bus.data_valid;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic bit m_busy(input int e);
      return (e >= m_bs) && (e < m_bs + m_bl);
   endfunction

   function automatic int busy_run(input int a);
      int n = 0;
      while (n < 200 && (a + n) < HN && bh[a + n] === 1'b1)
         n++;
      return n;
   endfunction

   function automatic int pulses(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++)
         n += int'(cvh[i] === 1'b1) + int'(dvh[i] === 1'b1);
      return n;
   endfunction

   task automatic model_reset;
      for (int i = 0; i < 32; i++)
         m_sh[i] = 8'h20;
      m_cur = 5'd0;
      m_inc = 1'b1;
      m_don = 1'b0;
      m_err = 1'b0;
      m_cb  = 8'h00;
      m_bs  = 0;
      m_bl  = 0;
   endtask

   // Effect of one EN strobe whose result lands on edge a.
   task automatic model_apply(input bit rs, input bit rw, input bit on,
                              input logic [7:0] d, input int a,
                              output bit ec, output bit ed);
      logic [6:0] ad;
      ec = 1'b0;
      ed = 1'b0;
      if (rw || !on)
         return;
      if (m_busy(a - 1)) begin
         m_err = 1'b1;
         return;
      end
      m_cb = d;
      m_bs = a;
      m_bl = BC;
      if (rs) begin
         ed = 1'b1;
         m_sh[m_cur] = d;
         m_cur = 5'((int'(m_cur) + (m_inc ? 1 : 31)) % 32);
      end else begin
         ec = 1'b1;
         if (d == 8'h01) begin
            for (int i = 0; i < 32; i++)
               m_sh[i] = 8'h20;
            m_cur = 5'd0;
            m_inc = 1'b1;
            m_bl  = CC;
         end else if (d == 8'h02 || d == 8'h03) begin
            m_cur = 5'd0;
            m_bl  = CC;
         end else if (d >= 8'h04 && d <= 8'h07) begin
            m_inc = d[1];
         end else if (d >= 8'h08 && d <= 8'h0F) begin
            m_don = d[2];
         end else if (d >= 8'h80) begin
            ad = d[6:0];
            if (ad < 7'h10)
               m_cur = ad[4:0];
            else if (ad >= 7'h40 && ad <= 7'h4F)
               m_cur = 5'(16 + int'(ad) - 64);
            else
               m_err = 1'b1;
         end
      end
   endtask

   task automatic wait_until(input int e);
      while (cyc < e)
         @(negedge clk);
   endtask

   // EN high for one cycle; the first edge seeing it low is k0+2.
   task automatic strobe(input bit rs, input bit rw, input bit on,
                         input logic [7:0] d, output int a,
                         output bit ec, output bit ed);
      int k0;
      @(negedge clk);
      k0 = cyc;
      bus.LCD_DATA = d;
      bus.LCD_RS   = rs;
      bus.LCD_RW   = rw;
      bus.LCD_ON   = on;
      bus.LCD_EN   = 1'b1;
      @(negedge clk);
      bus.LCD_EN   = 1'b0;
      a = k0 + 4;
      model_apply(rs, rw, on, d, a, ec, ed);
   endtask

   task automatic read_byte(input logic [4:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.rd_addr = a;
      @(negedge clk);
      d = bus.rd_char;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      bus.LCD_EN = 1'b0;
      bus.LCD_RW = 1'b0;
      bus.LCD_ON = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset;
      logic [7:0] v;
      bus.LCD_DATA = 8'($urandom);
      bus.LCD_RS   = 1'b1;
      bus.LCD_RW   = 1'b0;
      bus.LCD_ON   = 1'b1;
      bus.LCD_EN   = 1'b1;
      bus.rd_addr  = 5'd3;
      repeat (4) @(negedge clk);
      n_chk++; if (bus.cursor !== 5'd0) begin n_err++;
         $display("FAIL rst_cursor: got %0d exp 0", bus.cursor); end
      n_chk++; if (bus.busy !== 1'b0) begin n_err++;
         $display("FAIL rst_busy: got %b exp 0", bus.busy); end
      n_chk++; if (bus.display_on !== 1'b0) begin n_err++;
         $display("FAIL rst_disp: got %b exp 0", bus.display_on); end
      n_chk++; if ({bus.cmd_valid, bus.data_valid} !== 2'b00) begin n_err++;
         $display("FAIL rst_valid: got %b%b exp 00", bus.cmd_valid, bus.data_valid); end
      n_chk++; if (bus.cmd_byte !== 8'h00) begin n_err++;
         $display("FAIL rst_cmd_byte: got %h exp 00", bus.cmd_byte); end
      n_chk++; if (bus.protocol_err !== 1'b0) begin n_err++;
         $display("FAIL rst_err: got %b exp 0", bus.protocol_err); end
      n_chk++; if (bus.rd_char !== 8'h00) begin n_err++;
         $display("FAIL rst_rd_char: got %h exp 00", bus.rd_char); end
      bus.LCD_EN = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 32; i++) begin
         read_byte(5'(i), v);
         n_chk++; if (v !== 8'h20) begin n_err++;
            $display("FAIL rst_shadow[%0d]: got %h exp 20", i, v); end
      end
   endtask

   task automatic test_data;
      int a1, a2;
      bit ec, ed;
      logic [7:0] v;
      do_reset();
      strobe(1'b1, 1'b0, 1'b1, 8'h41, a1, ec, ed);
      repeat (10) @(negedge clk);
      strobe(1'b1, 1'b0, 1'b1, 8'h42, a2, ec, ed);
      wait_until(a2 + BC + 2);
      n_chk++; if ({dvh[a1 - 1], dvh[a1], dvh[a1 + 1]} !== 3'b010) begin n_err++;
         $display("FAIL data1_pulse: got %b exp 010", {dvh[a1 - 1], dvh[a1], dvh[a1 + 1]}); end
      n_chk++; if ({dvh[a2 - 1], dvh[a2], dvh[a2 + 1]} !== 3'b010) begin n_err++;
         $display("FAIL data2_pulse: got %b exp 010", {dvh[a2 - 1], dvh[a2], dvh[a2 + 1]}); end
      n_chk++; if (busy_run(a1) !== BC || bh[a1 - 1] !== 1'b0) begin n_err++;
         $display("FAIL data1_busy_len: got %0d exp %0d", busy_run(a1), BC); end
      n_chk++; if (busy_run(a2) !== BC) begin n_err++;
         $display("FAIL data2_busy_len: got %0d exp %0d", busy_run(a2), BC); end
      n_chk++; if (bus.cursor !== m_cur) begin n_err++;
         $display("FAIL data_cursor: got %0d exp %0d", bus.cursor, m_cur); end
      for (int i = 0; i < 2; i++) begin
         read_byte(5'(i), v);
         n_chk++; if (v !== m_sh[i]) begin n_err++;
            $display("FAIL data_shadow[%0d]: got %h exp %h", i, v, m_sh[i]); end
      end
   endtask

   task automatic test_set_address;
      int a;
      bit ec, ed;
      logic [7:0] v;
      do_reset();
      strobe(1'b0, 1'b0, 1'b1, 8'hC5, a, ec, ed);
      wait_until(a + BC + 1);
      n_chk++; if (cvh[a] !== ec || bus.cursor !== m_cur) begin n_err++;
         $display("FAIL addr_c5: got valid=%b cur=%0d exp valid=%b cur=%0d", cvh[a], bus.cursor, ec, m_cur); end
      strobe(1'b1, 1'b0, 1'b1, 8'h5A, a, ec, ed);
      wait_until(a + BC + 1);
      n_chk++; if (bus.cursor !== m_cur) begin n_err++;
         $display("FAIL addr_cursor: got %0d exp %0d", bus.cursor, m_cur); end
      n_chk++; if (bus.cmd_byte !== m_cb) begin n_err++;
         $display("FAIL addr_cmd_byte: got %h exp %h", bus.cmd_byte, m_cb); end
      read_byte(5'd21, v);
      n_chk++; if (v !== m_sh[21]) begin n_err++;
         $display("FAIL addr_shadow21: got %h exp %h", v, m_sh[21]); end
      strobe(1'b0, 1'b0, 1'b1, 8'h90, a, ec, ed);
      wait_until(a + BC + 1);
      n_chk++; if (bus.protocol_err !== m_err || cvh[a] !== ec) begin n_err++;
         $display("FAIL addr_bad: got err=%b valid=%b exp err=%b valid=%b", bus.protocol_err, cvh[a], m_err, ec); end
      n_chk++; if (bus.cursor !== m_cur) begin n_err++;
         $display("FAIL addr_bad_cursor: got %0d exp %0d", bus.cursor, m_cur); end
   endtask

   task automatic test_entry_mode;
      int a;
      bit ec, ed;
      logic [7:0] v;
      do_reset();
      strobe(1'b0, 1'b0, 1'b1, 8'h04, a, ec, ed);
      wait_until(a + BC + 1);
      strobe(1'b0, 1'b0, 1'b1, 8'h80, a, ec, ed);
      wait_until(a + BC + 1);
      strobe(1'b1, 1'b0, 1'b1, 8'h33, a, ec, ed);
      wait_until(a + BC + 1);
      n_chk++; if (bus.cursor !== m_cur) begin n_err++;
         $display("FAIL entry_wrap_cursor: got %0d exp %0d", bus.cursor, m_cur); end
      for (int i = 0; i < 6; i++) begin
         strobe(1'b1, 1'b0, 1'b1, 8'($urandom), a, ec, ed);
         wait_until(a + BC + 1);
      end
      n_chk++; if (bus.cursor !== m_cur) begin n_err++;
         $display("FAIL entry_dec_cursor: got %0d exp %0d", bus.cursor, m_cur); end
      for (int i = 0; i < 32; i++) begin
         read_byte(5'(i), v);
         n_chk++; if (v !== m_sh[i]) begin n_err++;
            $display("FAIL entry_shadow[%0d]: got %h exp %h", i, v, m_sh[i]); end
      end
   endtask

   task automatic test_clear;
      int a, ac, ad;
      bit ec, ed;
      logic [7:0] v;
      logic [4:0] ra;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         strobe(1'b0, 1'b0, 1'b1,
                {1'b1, 1'($urandom_range(0, 1)), 2'b00, 4'($urandom_range(0, 15))},
                a, ec, ed);
         wait_until(a + BC + 1);
         strobe(1'b1, 1'b0, 1'b1, 8'($urandom_range(8'h21, 8'h7E)), a, ec, ed);
         wait_until(a + BC + 1);
      end
      for (int i = 0; i < 4; i++) begin
         ra = 5'($urandom_range(0, 31));
         read_byte(ra, v);
         n_chk++; if (v !== m_sh[ra]) begin n_err++;
            $display("FAIL fill_shadow[%0d]: got %h exp %h", ra, v, m_sh[ra]); end
      end
      strobe(1'b0, 1'b0, 1'b1, 8'h01, ac, ec, ed);
      wait_until(ac + 15);
      strobe(1'b1, 1'b0, 1'b1, 8'h7E, ad, ec, ed);
      wait_until(ad + 1);
      n_chk++; if (dvh[ad] !== ed || bus.protocol_err !== m_err) begin n_err++;
         $display("FAIL clear_drop: got valid=%b err=%b exp valid=%b err=%b", dvh[ad], bus.protocol_err, ed, m_err); end
      wait_until(ac + CC + 2);
      n_chk++; if (busy_run(ac) !== CC || bh[ac - 1] !== 1'b0) begin n_err++;
         $display("FAIL clear_busy_len: got %0d exp %0d", busy_run(ac), CC); end
      n_chk++; if (bus.cursor !== m_cur) begin n_err++;
         $display("FAIL clear_cursor: got %0d exp %0d", bus.cursor, m_cur); end
      for (int i = 0; i < 32; i++) begin
         read_byte(5'(i), v);
         n_chk++; if (v !== m_sh[i]) begin n_err++;
            $display("FAIL clear_shadow[%0d]: got %h exp %h", i, v, m_sh[i]); end
      end
   endtask

   task automatic test_ignored;
      int a, a0;
      bit ec, ed, rw, on;
      int exp_p;
      logic [7:0] v;
      do_reset();
      exp_p = 0;
      a0 = 0;
      for (int i = 0; i < 10; i++) begin
         rw = 1'($urandom_range(0, 1));
         on = rw ? 1'($urandom_range(0, 1)) : 1'b0;
         strobe(1'($urandom_range(0, 1)), rw, on, 8'($urandom), a, ec, ed);
         if (i == 0) a0 = a;
         exp_p += int'(ec) + int'(ed);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_until(a + 3);
      n_chk++; if (pulses(a0 - 1, a + 2) !== exp_p) begin n_err++;
         $display("FAIL ign_pulses: got %0d exp %0d", pulses(a0 - 1, a + 2), exp_p); end
      n_chk++; if (bus.protocol_err !== m_err || bus.busy !== 1'b0) begin n_err++;
         $display("FAIL ign_err_busy: got err=%b busy=%b exp err=%b busy=0", bus.protocol_err, bus.busy, m_err); end
      for (int i = 0; i < 32; i++) begin
         read_byte(5'(i), v);
         n_chk++; if (v !== m_sh[i]) begin n_err++;
            $display("FAIL ign_shadow[%0d]: got %h exp %h", i, v, m_sh[i]); end
      end
      strobe(1'b0, 1'b0, 1'b1, 8'h0C, a, ec, ed);
      wait_until(a + BC + 1);
      n_chk++; if (bus.display_on !== m_don || cvh[a] !== ec) begin n_err++;
         $display("FAIL disp_on: got on=%b valid=%b exp on=%b valid=%b", bus.display_on, cvh[a], m_don, ec); end
   endtask

   task automatic test_back_to_back;
      int aq[$];
      bit ecq[$];
      bit edq[$];
      int a;
      bit ec, ed;
      int exp_p;
      logic [7:0] v;
      do_reset();
      exp_p = 0;
      for (int i = 0; i < 40; i++) begin
         strobe(1'($urandom_range(0, 1)), 1'b0, 1'b1, 8'($urandom), a, ec, ed);
         aq.push_back(a);
         ecq.push_back(ec);
         edq.push_back(ed);
         exp_p += int'(ec) + int'(ed);
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      wait_until(a + CC + 2);
      for (int i = 0; i < aq.size(); i++) begin
         n_chk++; if (cvh[aq[i]] !== ecq[i] || dvh[aq[i]] !== edq[i]) begin n_err++;
            $display("FAIL b2b_pulse[%0d]: got c=%b d=%b exp c=%b d=%b", i, cvh[aq[i]], dvh[aq[i]], ecq[i], edq[i]); end
      end
      n_chk++; if (pulses(aq[0] - 1, a + 2) !== exp_p) begin n_err++;
         $display("FAIL b2b_pulse_count: got %0d exp %0d", pulses(aq[0] - 1, a + 2), exp_p); end
      n_chk++; if (bus.cursor !== m_cur || bus.protocol_err !== m_err) begin n_err++;
         $display("FAIL b2b_state: got cur=%0d err=%b exp cur=%0d err=%b", bus.cursor, bus.protocol_err, m_cur, m_err); end
      n_chk++; if (bus.display_on !== m_don || bus.cmd_byte !== m_cb) begin n_err++;
         $display("FAIL b2b_disp_cb: got on=%b cb=%h exp on=%b cb=%h", bus.display_on, bus.cmd_byte, m_don, m_cb); end
      for (int i = 0; i < 32; i++) begin
         read_byte(5'(i), v);
         n_chk++; if (v !== m_sh[i]) begin n_err++;
            $display("FAIL b2b_shadow[%0d]: got %h exp %h", i, v, m_sh[i]); end
      end
   endtask

   task automatic test_reset_mid_clear;
      int a, ac;
      bit ec, ed;
      logic [7:0] v;
      do_reset();
      strobe(1'b1, 1'b0, 1'b1, 8'h55, a, ec, ed);
      wait_until(a + BC + 1);
      strobe(1'b0, 1'b0, 1'b1, 8'h01, ac, ec, ed);
      wait_until(ac + 9);
      rst_n = 1'b0;
      @(negedge clk);
      n_chk++; if (bh[ac + 9] !== 1'b1 || bus.busy !== 1'b0) begin n_err++;
         $display("FAIL midclr_busy: got before=%b after=%b exp before=1 after=0", bh[ac + 9], bus.busy); end
      rst_n = 1'b1;
      model_reset();
      strobe(1'b1, 1'b0, 1'b1, 8'h61, a, ec, ed);
      wait_until(a + BC + 1);
      n_chk++; if (dvh[a] !== ed || bus.cursor !== m_cur) begin n_err++;
         $display("FAIL midclr_write: got valid=%b cur=%0d exp valid=%b cur=%0d", dvh[a], bus.cursor, ed, m_cur); end
      for (int i = 0; i < 32; i++) begin
         read_byte(5'(i), v);
         n_chk++; if (v !== m_sh[i]) begin n_err++;
            $display("FAIL midclr_shadow[%0d]: got %h exp %h", i, v, m_sh[i]); end
      end
   endtask

   initial begin
      bus.LCD_DATA = 8'h00;
      bus.LCD_RS   = 1'b0;
      bus.LCD_RW   = 1'b0;
      bus.LCD_EN   = 1'b0;
      bus.LCD_ON   = 1'b1;
      bus.rd_addr  = 5'd0;
      model_reset();
      test_reset();
      test_data();
      test_set_address();
      test_entry_mode();
      test_clear();
      test_ignored();
      test_back_to_back();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
